// File: rtl/vga_pattern_pkg.sv
// vga_pattern_pkg
//   Shared definitions for the VGA test-pattern generator:
//   - mode_e    : pattern select encodings (grid, colour bars, checker, scrolling checker)
//   - CNT_W     : width of the x/y raster counters
//   - DEF_*     : default 640x480@60 timing
//   - bar_index : maps a pixel column to a colour-bar index using constant thresholds
package vga_pattern_pkg;

    localparam int CNT_W = 11;

    typedef enum logic [1:0] {
        MODE_GRID   = 2'd0,
        MODE_BARS   = 2'd1,
        MODE_CHECK  = 2'd2,
        MODE_SCROLL = 2'd3
    } mode_e;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    // Bar b covers k*h_active/8 <= x < (k+1)*h_active/8. h_active is always an
    // elaboration-time constant, so this reduces to seven constant comparators.
    function automatic logic [2:0] bar_index(input logic [CNT_W-1:0] x, input int h_active);
        logic [2:0] bar;
        bar = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (x >= CNT_W'((k * h_active) / 8)) begin
                bar = 3'(k);
            end
        end
        return bar;
    endfunction

endpackage

// File: rtl/vga_sync_counter.sv
// vga_sync_counter
//   Free-running raster counters for a programmable VGA timing.
//   Ports:
//     clk, rst_n   : pixel clock, asynchronous active-low reset
//     x, y         : current pixel column / line (CNT_W bits, registered)
//     active       : x,y lies inside the visible area
//     hsync_raw    : x inside the hsync pulse window (active-high, unpolarised)
//     vsync_raw    : y inside the vsync pulse window (active-high, unpolarised)
//     frame_first  : counters sit at (0,0)
//     frame_last   : counters sit at (H_TOTAL-1, V_TOTAL-1)
module vga_sync_counter
    import vga_pattern_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             active,
    output logic             hsync_raw,
    output logic             vsync_raw,
    output logic             frame_first,
    output logic             frame_last
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS      = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_VIS      = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START   = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END     = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START   = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END     = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic [CNT_W-1:0] x_r;
    logic [CNT_W-1:0] y_r;

    // Raster counters: x wraps every line, y advances on each x wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_r <= CNT_ZERO;
            y_r <= CNT_ZERO;
        end else if (x_r == H_LAST) begin
            x_r <= CNT_ZERO;
            if (y_r == V_LAST) begin
                y_r <= CNT_ZERO;
            end else begin
                y_r <= y_r + CNT_ONE;
            end
        end else begin
            x_r <= x_r + CNT_ONE;
        end
    end

    assign x           = x_r;
    assign y           = y_r;
    assign active      = (x_r < H_VIS) && (y_r < V_VIS);
    assign hsync_raw   = (x_r >= HS_START) && (x_r < HS_END);
    assign vsync_raw   = (y_r >= VS_START) && (y_r < VS_END);
    assign frame_first = (x_r == CNT_ZERO) && (y_r == CNT_ZERO);
    assign frame_last  = (x_r == H_LAST) && (y_r == V_LAST);

endmodule

// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen
//   VGA test-pattern generator with its own programmable timing.
//   Ports:
//     CLK_PIXEL, RESET_N  : pixel clock, asynchronous active-low reset
//     MODE                : pattern select (grid / colour bars / checker / scrolling checker),
//                           latched only at pixel (0,0) so frames are never torn
//     VGA_RED/GREEN/BLUE  : registered colour channels, COLOR_BITS each, zero in blanking
//     VGA_HSYNC/VGA_VSYNC : registered syncs, polarity from SYNC_ACTIVE_HIGH
//     FRAME_START         : one-cycle pulse together with the first active pixel at the outputs
//     FRAME_COUNT         : completed-frame counter, wraps 255 -> 0
//   Build option: define VGA_PATTERN_BORDER_EN to overlay a 1-pixel white border on
//   the edge of the visible area.
module vga_pattern_gen
    import vga_pattern_pkg::*;
#(
    parameter int COLOR_BITS       = 1,
    parameter int H_ACTIVE         = DEF_H_ACTIVE,
    parameter int H_FP             = DEF_H_FP,
    parameter int H_SYNC           = DEF_H_SYNC,
    parameter int H_BP             = DEF_H_BP,
    parameter int V_ACTIVE         = DEF_V_ACTIVE,
    parameter int V_FP             = DEF_V_FP,
    parameter int V_SYNC           = DEF_V_SYNC,
    parameter int V_BP             = DEF_V_BP,
    parameter int SYNC_ACTIVE_HIGH = 0,
    parameter int CELL_LOG2        = 3
) (
    input  logic                  CLK_PIXEL,
    input  logic                  RESET_N,
    input  logic [1:0]            MODE,
    output logic [COLOR_BITS-1:0] VGA_RED,
    output logic [COLOR_BITS-1:0] VGA_GREEN,
    output logic [COLOR_BITS-1:0] VGA_BLUE,
    output logic                  VGA_HSYNC,
    output logic                  VGA_VSYNC,
    output logic                  FRAME_START,
    output logic [7:0]            FRAME_COUNT
);

    // Idle sync level; XOR with the raw pulse yields the polarised sync.
    localparam logic SYNC_IDLE = (SYNC_ACTIVE_HIGH != 0) ? 1'b0 : 1'b1;
    localparam logic [COLOR_BITS-1:0] CH_ON  = {COLOR_BITS{1'b1}};
    localparam logic [COLOR_BITS-1:0] CH_OFF = {COLOR_BITS{1'b0}};
    localparam logic [CELL_LOG2-1:0]  CELL_ZERO = {CELL_LOG2{1'b0}};

    logic [CNT_W-1:0] x_s;
    logic [CNT_W-1:0] y_s;
    logic [CNT_W-1:0] x_scroll_s;
    logic             active_s;
    logic             hsync_raw_s;
    logic             vsync_raw_s;
    logic             frame_first_s;
    logic             frame_last_s;

    mode_e            mode_q_r;
    mode_e            mode_eff_s;
    logic [7:0]       frame_count_r;
    logic [2:0]       bar_s;
    logic             pat_r_s;
    logic             pat_g_s;
    logic             pat_b_s;
    logic             border_s;

    logic [COLOR_BITS-1:0] red_next_s;
    logic [COLOR_BITS-1:0] green_next_s;
    logic [COLOR_BITS-1:0] blue_next_s;
    logic                  hsync_next_s;
    logic                  vsync_next_s;

    logic [COLOR_BITS-1:0] red_r;
    logic [COLOR_BITS-1:0] green_r;
    logic [COLOR_BITS-1:0] blue_r;
    logic                  hsync_r;
    logic                  vsync_r;
    logic                  frame_start_r;

    logic                  unused_bits_s;

    vga_sync_counter #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_sync (
        .clk         (CLK_PIXEL),
        .rst_n       (RESET_N),
        .x           (x_s),
        .y           (y_s),
        .active      (active_s),
        .hsync_raw   (hsync_raw_s),
        .vsync_raw   (vsync_raw_s),
        .frame_first (frame_first_s),
        .frame_last  (frame_last_s)
    );

    // Mode latch and frame counter. The latch loads at (0,0) only.
    always_ff @(posedge CLK_PIXEL or negedge RESET_N) begin
        if (!RESET_N) begin
            mode_q_r      <= MODE_GRID;
            frame_count_r <= 8'd0;
        end else begin
            if (frame_first_s) begin
                mode_q_r <= mode_e'(MODE);
            end
            if (frame_last_s) begin
                frame_count_r <= frame_count_r + 8'd1;
            end
        end
    end

    // Pixel (0,0) is rendered in the same cycle the latch loads, so it must
    // already see the incoming MODE; otherwise the first pixel of each frame
    // would belong to the previous mode.
    assign mode_eff_s = frame_first_s ? mode_e'(MODE) : mode_q_r;

    // Scrolling x wraps modulo 2^CNT_W by construction.
    assign x_scroll_s = x_s + {{(CNT_W-8){1'b0}}, frame_count_r};
    assign bar_s      = bar_index(x_s, H_ACTIVE);

`ifdef VGA_PATTERN_BORDER_EN
    localparam logic [CNT_W-1:0] X_EDGE = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] Y_EDGE = CNT_W'(V_ACTIVE - 1);
    assign border_s = (x_s == {CNT_W{1'b0}}) || (x_s == X_EDGE) ||
                      (y_s == {CNT_W{1'b0}}) || (y_s == Y_EDGE);
`else
    assign border_s = 1'b0;
`endif

    // Pattern select: per-channel on/off for the current pixel before blanking.
    always_comb begin
        pat_r_s = 1'b0;
        pat_g_s = 1'b0;
        pat_b_s = 1'b0;
        case (mode_eff_s)
            MODE_GRID: begin
                pat_r_s = (x_s[CELL_LOG2-1:0] == CELL_ZERO) || (y_s[CELL_LOG2-1:0] == CELL_ZERO);
                pat_g_s = y_s[CELL_LOG2+1];
                pat_b_s = x_s[CELL_LOG2+1];
            end
            MODE_BARS: begin
                pat_r_s = bar_s[2];
                pat_g_s = bar_s[1];
                pat_b_s = bar_s[0];
            end
            MODE_CHECK: begin
                pat_r_s = x_s[CELL_LOG2] ^ y_s[CELL_LOG2];
                pat_g_s = pat_r_s;
                pat_b_s = pat_r_s;
            end
            MODE_SCROLL: begin
                pat_r_s = x_scroll_s[CELL_LOG2] ^ y_s[CELL_LOG2];
                pat_g_s = pat_r_s;
                pat_b_s = pat_r_s;
            end
            default: begin
                pat_r_s = 1'b0;
                pat_g_s = 1'b0;
                pat_b_s = 1'b0;
            end
        endcase
    end

    // Blanking forces black; the border (when built in) overrides the pattern.
    assign red_next_s   = (active_s && (pat_r_s || border_s)) ? CH_ON : CH_OFF;
    assign green_next_s = (active_s && (pat_g_s || border_s)) ? CH_ON : CH_OFF;
    assign blue_next_s  = (active_s && (pat_b_s || border_s)) ? CH_ON : CH_OFF;
    assign hsync_next_s = hsync_raw_s ^ SYNC_IDLE;
    assign vsync_next_s = vsync_raw_s ^ SYNC_IDLE;

    // Output stage: everything registered from one counter state to stay aligned.
    always_ff @(posedge CLK_PIXEL or negedge RESET_N) begin
        if (!RESET_N) begin
            red_r         <= CH_OFF;
            green_r       <= CH_OFF;
            blue_r        <= CH_OFF;
            hsync_r       <= SYNC_IDLE;
            vsync_r       <= SYNC_IDLE;
            frame_start_r <= 1'b0;
        end else begin
            red_r         <= red_next_s;
            green_r       <= green_next_s;
            blue_r        <= blue_next_s;
            hsync_r       <= hsync_next_s;
            vsync_r       <= vsync_next_s;
            frame_start_r <= frame_first_s;
        end
    end

    assign VGA_RED     = red_r;
    assign VGA_GREEN   = green_r;
    assign VGA_BLUE    = blue_r;
    assign VGA_HSYNC   = hsync_r;
    assign VGA_VSYNC   = vsync_r;
    assign FRAME_START = frame_start_r;
    assign FRAME_COUNT = frame_count_r;

    // Only a few bits of these vectors feed the pattern logic.
    assign unused_bits_s = ^{x_scroll_s, y_s};

endmodule

// File: tb/tb_vga_pattern_gen.sv
// tb_vga_pattern_gen
//   Self-checking bench for vga_pattern_gen. The raster is shrunk (24x13 total,
//   20x10 visible) so that 256 frames fit in a short run; the timing checks use
//   the same formulas as the full 640x480 mode, scaled to these parameters.
//   Expected outputs are pushed to queues when the pixel is presented to the DUT
//   and popped one clock later when the registered outputs appear.
module tb_vga_pattern_gen;

    localparam int CB  = 2;
    localparam int HA  = 20;
    localparam int HFP = 1;
    localparam int HS  = 2;
    localparam int HBP = 1;
    localparam int VA  = 10;
    localparam int VFP = 1;
    localparam int VS  = 1;
    localparam int VBP = 1;
    localparam int HT  = HA + HFP + HS + HBP;
    localparam int VT  = VA + VFP + VS + VBP;
    localparam int FRAME = HT * VT;

`ifdef VGA_PATTERN_BORDER_EN
    localparam bit BORDER = 1'b1;
`else
    localparam bit BORDER = 1'b0;
`endif

    typedef struct packed {
        logic [CB-1:0] r;
        logic [CB-1:0] g;
        logic [CB-1:0] b;
        logic          hs;
        logic          vs;
        logic          fs;
        logic [7:0]    fc;
    } out_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    mode;
    logic [CB-1:0] vga_red;
    logic [CB-1:0] vga_green;
    logic [CB-1:0] vga_blue;
    logic          vga_hsync;
    logic          vga_vsync;
    logic          frame_start;
    logic [7:0]    frame_count;

    int total = 0;
    int bad   = 0;

    out_t       out_q[$];
    logic [5:0] rgb_q[$];

    // Reference raster position, frame count and latched mode of the pixel
    // about to be registered at the next rising edge.
    int mx, my, mfc, mmode;

    always #5 clk = ~clk;

    vga_pattern_gen #(
        .COLOR_BITS       (CB),
        .H_ACTIVE         (HA),
        .H_FP             (HFP),
        .H_SYNC           (HS),
        .H_BP             (HBP),
        .V_ACTIVE         (VA),
        .V_FP             (VFP),
        .V_SYNC           (VS),
        .V_BP             (VBP),
        .SYNC_ACTIVE_HIGH (0),
        .CELL_LOG2        (3)
    ) dut (
        .CLK_PIXEL   (clk),
        .RESET_N     (rst_n),
        .MODE        (mode),
        .VGA_RED     (vga_red),
        .VGA_GREEN   (vga_green),
        .VGA_BLUE    (vga_blue),
        .VGA_HSYNC   (vga_hsync),
        .VGA_VSYNC   (vga_vsync),
        .FRAME_START (frame_start),
        .FRAME_COUNT (frame_count)
    );

    // Reference raster tracker.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mx <= 0; my <= 0; mfc <= 0; mmode <= 0;
        end else begin
            if (mx == 0 && my == 0) mmode <= int'(mode);
            if (mx == HT - 1 && my == VT - 1) mfc <= (mfc + 1) % 256;
            if (mx == HT - 1) begin
                mx <= 0;
                my <= (my == VT - 1) ? 0 : my + 1;
            end else begin
                mx <= mx + 1;
            end
        end
    end

    // Expected registered outputs for pixel (x,y) rendered in mode md with frame count fc.
    function automatic out_t model_out(int x, int y, int fc, int md);
        out_t o;
        bit act, on_r, on_g, on_b;
        int bi;
        int bounds[8];
        bounds = '{0, 2, 5, 7, 10, 12, 15, 17};  // k*20/8 rounded down
        o = '0; on_r = 0; on_g = 0; on_b = 0;
        act = (x < HA) && (y < VA);
        case (md)
            0: begin
                on_r = (x % 8 == 0) || (y % 8 == 0);
                on_g = ((y >> 4) & 1) == 1;
                on_b = ((x >> 4) & 1) == 1;
            end
            1: begin
                bi = 0;
                for (int k = 1; k < 8; k++) if (x >= bounds[k]) bi = k;
                on_r = ((bi >> 2) & 1) == 1;
                on_g = ((bi >> 1) & 1) == 1;
                on_b = (bi & 1) == 1;
            end
            2: begin
                on_r = (((x >> 3) ^ (y >> 3)) & 1) == 1;
                on_g = on_r; on_b = on_r;
            end
            default: begin
                on_r = (((((x + fc) % 2048) >> 3) ^ (y >> 3)) & 1) == 1;
                on_g = on_r; on_b = on_r;
            end
        endcase
        if (BORDER && (x == 0 || x == HA - 1 || y == 0 || y == VA - 1)) begin
            on_r = 1; on_g = 1; on_b = 1;
        end
        o.r  = (act && on_r) ? 2'b11 : 2'b00;
        o.g  = (act && on_g) ? 2'b11 : 2'b00;
        o.b  = (act && on_b) ? 2'b11 : 2'b00;
        o.hs = !(x >= HA + HFP && x < HA + HFP + HS);
        o.vs = !(y >= VA + VFP && y < VA + VFP + VS);
        o.fs = (x == 0 && y == 0);
        o.fc = (x == HT - 1 && y == VT - 1) ? 8'((fc + 1) % 256) : 8'(fc);
        return o;
    endfunction

    function automatic out_t expect_now();
        int md;
        md = (mx == 0 && my == 0) ? int'(mode) : mmode;
        return model_out(mx, my, mfc, md);
    endfunction

    function automatic out_t dut_now();
        out_t o;
        o.r = vga_red; o.g = vga_green; o.b = vga_blue;
        o.hs = vga_hsync; o.vs = vga_vsync; o.fs = frame_start; o.fc = frame_count;
        return o;
    endfunction

    // Advance to the falling edge where the reference raster sits at (px,py)
    // (and frame count fcw, unless fcw < 0). Returns ok=0 if limit expires.
    task automatic wait_pixel(input int px, input int py, input int fcw, input int limit, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < limit; n++) begin
            @(negedge clk);
            if (mx == px && my == py && (fcw < 0 || mfc == fcw)) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic test_reset();
        out_t rst_exp, got, e;
        rst_exp = '0; rst_exp.hs = 1'b1; rst_exp.vs = 1'b1;
        rst_n = 1'b0;
        mode  = 2'd0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            got = dut_now();
            total++;
            if (got !== rst_exp) begin
                bad++;
                $display("FAIL reset_hold[%0d] got=%h exp=%h", i, got, rst_exp);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        out_q.push_back(expect_now());
        @(posedge clk); #1;
        got = dut_now();
        e = out_q.pop_front();
        total++;
        if (got !== e || frame_start !== 1'b1) begin
            bad++;
            $display("FAIL first_frame_start got=%h exp=%h", got, e);
        end
    endtask

    task automatic test_grid();
        int gx[3];
        int gy[3];
        logic [5:0] ge[3];
        logic [5:0] got, e;
        bit ok;
        gx = '{16, 8, 9};
        gy = '{0, 5, 9};
        ge[0] = BORDER ? 6'b111111 : 6'b110011;
        ge[1] = 6'b110000;
        ge[2] = BORDER ? 6'b111111 : 6'b000000;
        for (int i = 0; i < 3; i++) begin
            wait_pixel(gx[i], gy[i], -1, 2 * FRAME, ok);
            rgb_q.push_back(ge[i]);
            @(posedge clk); #1;
            got = {vga_red, vga_green, vga_blue};
            e = rgb_q.pop_front();
            total++;
            if (!ok || got !== e) begin
                bad++;
                $display("FAIL grid(%0d,%0d) got=%b exp=%b ok=%0d", gx[i], gy[i], got, e, ok);
            end
        end
    endtask

    task automatic test_bars();
        out_t got, e;
        bit ok, ok2;
        mode = 2'd1;
        wait_pixel(0, 0, -1, 2 * FRAME, ok);
        wait_pixel(0, 3, -1, 2 * FRAME, ok2);
        for (int i = 0; i < HT; i++) begin
            out_q.push_back(expect_now());
            @(posedge clk); #1;
            got = dut_now();
            e = out_q.pop_front();
            total++;
            if (!ok || !ok2 || got !== e) begin
                bad++;
                $display("FAIL bars x=%0d got=%h exp=%h", i, got, e);
            end
            if (i == 5) begin
                total++;
                if ({vga_red, vga_green, vga_blue} !== 6'b001100) begin
                    bad++;
                    $display("FAIL bars_x5 got=%b exp=%b", {vga_red, vga_green, vga_blue}, 6'b001100);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_mode_latch();
        logic [5:0] got, e;
        bit ok, ok2;
        mode = 2'd0;
        wait_pixel(0, 0, -1, 2 * FRAME, ok);
        wait_pixel(0, 5, -1, 2 * FRAME, ok2);
        mode = 2'd2;
        ok = ok && ok2;
        wait_pixel(8, 7, -1, FRAME, ok2);
        rgb_q.push_back(6'b110000);  // still grid: R on the cell line only
        @(posedge clk); #1;
        got = {vga_red, vga_green, vga_blue};
        e = rgb_q.pop_front();
        total++;
        if (!ok || !ok2 || got !== e) begin
            bad++;
            $display("FAIL latch_same_frame got=%b exp=%b", got, e);
        end
        wait_pixel(8, 0, -1, 2 * FRAME, ok2);
        rgb_q.push_back(6'b111111);  // checker now in force
        @(posedge clk); #1;
        got = {vga_red, vga_green, vga_blue};
        e = rgb_q.pop_front();
        total++;
        if (!ok2 || got !== e) begin
            bad++;
            $display("FAIL latch_next_frame got=%b exp=%b", got, e);
        end
    endtask

    task automatic test_sync();
        int hs_first, hs_second, hs_cnt0, vs_first, vs_cnt, fs_next;
        logic prev_hs;
        bit ok;
        hs_first = -1; hs_second = -1; hs_cnt0 = 0;
        vs_first = -1; vs_cnt = 0; fs_next = -1; prev_hs = 1'b1;
        wait_pixel(0, 0, -1, 2 * FRAME, ok);
        @(posedge clk); #1;
        for (int i = 0; i <= FRAME; i++) begin
            if (i > 0 && frame_start === 1'b1 && fs_next < 0) fs_next = i;
            if (i < FRAME) begin
                if (vga_hsync === 1'b0 && prev_hs === 1'b1) begin
                    if (hs_first < 0) hs_first = i;
                    else if (hs_second < 0) hs_second = i;
                end
                if (vga_hsync === 1'b0 && i < HT) hs_cnt0++;
                if (vga_vsync === 1'b0) begin
                    vs_cnt++;
                    if (vs_first < 0) vs_first = i;
                end
                prev_hs = vga_hsync;
            end
            @(posedge clk); #1;
        end
        total++;
        if (!ok || hs_first != HA + HFP) begin
            bad++; $display("FAIL hsync_start got=%0d exp=%0d", hs_first, HA + HFP);
        end
        total++;
        if (hs_second - hs_first != HT) begin
            bad++; $display("FAIL line_period got=%0d exp=%0d", hs_second - hs_first, HT);
        end
        total++;
        if (hs_cnt0 != HS) begin
            bad++; $display("FAIL hsync_width got=%0d exp=%0d", hs_cnt0, HS);
        end
        total++;
        if (vs_first != (VA + VFP) * HT) begin
            bad++; $display("FAIL vsync_start got=%0d exp=%0d", vs_first, (VA + VFP) * HT);
        end
        total++;
        if (vs_cnt != VS * HT) begin
            bad++; $display("FAIL vsync_width got=%0d exp=%0d", vs_cnt, VS * HT);
        end
        total++;
        if (fs_next != FRAME) begin
            bad++; $display("FAIL frame_period got=%0d exp=%0d", fs_next, FRAME);
        end
    endtask

    task automatic test_midframe_reset();
        out_t rst_exp, got, e;
        logic [5:0] grgb;
        bit ok, ok2;
        rst_exp = '0; rst_exp.hs = 1'b1; rst_exp.vs = 1'b1;
        wait_pixel(10, 4, -1, 2 * FRAME, ok);
        rst_n = 1'b0;
        #1;
        got = dut_now();
        total++;
        if (!ok || got !== rst_exp) begin
            bad++;
            $display("FAIL midframe_reset got=%h exp=%h", got, rst_exp);
        end
        repeat (2) @(negedge clk);
        mode  = 2'd2;
        rst_n = 1'b1;
        out_q.push_back(expect_now());
        @(posedge clk); #1;
        got = dut_now();
        e = out_q.pop_front();
        total++;
        if (got !== e) begin
            bad++;
            $display("FAIL restart_origin got=%h exp=%h", got, e);
        end
        wait_pixel(8, 0, -1, FRAME, ok2);
        rgb_q.push_back(6'b111111);
        @(posedge clk); #1;
        grgb = {vga_red, vga_green, vga_blue};
        total++;
        if (!ok2 || grgb !== rgb_q.pop_front()) begin
            bad++;
            $display("FAIL restart_mode got=%b exp=%b", grgb, 6'b111111);
        end
    endtask

`ifdef VGA_PATTERN_BORDER_EN
    task automatic test_border();
        int bx[3];
        int by[3];
        logic [5:0] be[3];
        logic [5:0] got, e;
        bit ok;
        bx = '{1, 0, HA - 1};
        by = '{1, 5, VA - 1};
        be = '{6'b000000, 6'b111111, 6'b111111};
        mode = 2'd2;
        for (int i = 0; i < 3; i++) begin
            wait_pixel(bx[i], by[i], -1, 2 * FRAME, ok);
            rgb_q.push_back(be[i]);
            @(posedge clk); #1;
            got = {vga_red, vga_green, vga_blue};
            e = rgb_q.pop_front();
            total++;
            if (!ok || got !== e) begin
                bad++;
                $display("FAIL border(%0d,%0d) got=%b exp=%b", bx[i], by[i], got, e);
            end
        end
    endtask
`endif

    task automatic test_scroll_wrap();
        out_t got, e;
        logic [5:0] grgb;
        bit ok;
        mode = 2'd3;
        wait_pixel(0, 0, 255, 260 * FRAME, ok);
        out_q.push_back(expect_now());
        @(posedge clk); #1;
        got = dut_now();
        e = out_q.pop_front();
        total++;
        if (!ok || got !== e) begin
            bad++;
            $display("FAIL scroll_fc255 got=%h exp=%h", got, e);
        end
        wait_pixel(0, 0, 0, 2 * FRAME, ok);
        out_q.push_back(expect_now());
        @(posedge clk); #1;
        got = dut_now();
        e = out_q.pop_front();
        total++;
        if (!ok || got !== e || frame_count !== 8'd0) begin
            bad++;
            $display("FAIL fc_wrap got=%h exp=%h", got, e);
        end
        wait_pixel(7, 0, 1, 2 * FRAME, ok);
        rgb_q.push_back(6'b111111);
        @(posedge clk); #1;
        grgb = {vga_red, vga_green, vga_blue};
        total++;
        if (!ok || grgb !== rgb_q.pop_front()) begin
            bad++;
            $display("FAIL scroll_pixel7 got=%b exp=%b", grgb, 6'b111111);
        end
    endtask

    initial begin
        test_reset();
        test_grid();
        test_bars();
        test_mode_latch();
        test_sync();
        test_midframe_reset();
`ifdef VGA_PATTERN_BORDER_EN
        test_border();
`endif
        test_scroll_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Last-resort guard against a stalled run.
    initial begin
        #950000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
